// File: rtl/divided_clk_period_meter.sv
// rtl/divided_clk_period_meter.sv - half-period meter reporting div_clk_count encoding
// Optional MEAS_MATCH_EN adds expected_count/match compare ports.
module divided_clk_period_meter #(
   parameter int          SYNC_STAGES    = 2,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
   parameter logic [31:0] LOCK_TOL       = 32'd1,
   parameter logic [31:0] MATCH_TOL      = 32'd2
) (
   input  logic        inclk,
   input  logic        Reset,
   input  logic        sig_in,
`ifdef MEAS_MATCH_EN
   input  logic [31:0] expected_count,
   output logic        match,
`endif
   output logic [31:0] half_period_count,
   output logic        meas_valid,
   output logic        locked,
   output logic        timeout
);

   typedef enum logic [1:0] {
      WAIT_EDGE = 2'd0,
      MEASURE   = 2'd1,
      TIMED_OUT = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sync_out;
   logic                   edge_det;
   logic [31:0]            cnt_q;
   logic [31:0]            prev_cap_q;
   logic                   has_prev_q;
   logic [31:0]            lock_diff;
   logic                   capture;
   logic                   clear_cnt;
   logic                   enter_to;

   assign sync_out  = sync_q[SYNC_STAGES-1];
   assign edge_det  = sync_out ^ prev_q;
   assign lock_diff = (cnt_q >= prev_cap_q) ? (cnt_q - prev_cap_q) : (prev_cap_q - cnt_q);

   always_ff @(posedge inclk or negedge Reset) begin
      if (!Reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         prev_q <= sync_out;
      end
   end

   always_ff @(posedge inclk or negedge Reset) begin
      if (!Reset) state_q <= WAIT_EDGE;
      else        state_q <= state_d;
   end

   // An edge in the same cycle as cnt==TIMEOUT_CYCLES is captured, not timed out.
   always_comb begin
      state_d   = state_q;
      capture   = 1'b0;
      clear_cnt = 1'b0;
      enter_to  = 1'b0;
      case (state_q)
         WAIT_EDGE: begin
            if (edge_det) begin
               clear_cnt = 1'b1;
               state_d   = MEASURE;
            end
         end
         MEASURE: begin
            if (edge_det) begin
               capture = 1'b1;
            end else if (cnt_q == TIMEOUT_CYCLES) begin
               enter_to = 1'b1;
               state_d  = TIMED_OUT;
            end
         end
         TIMED_OUT: begin
            if (edge_det) begin
               clear_cnt = 1'b1;
               state_d   = MEASURE;
            end
         end
         default: state_d = WAIT_EDGE;
      endcase
   end

   always_ff @(posedge inclk or negedge Reset) begin
      if (!Reset) begin
         cnt_q             <= '0;
         half_period_count <= '0;
         prev_cap_q        <= '0;
         has_prev_q        <= 1'b0;
         meas_valid        <= 1'b0;
         locked            <= 1'b0;
         timeout           <= 1'b0;
      end else begin
         meas_valid <= capture;
         if (capture || clear_cnt) begin
            cnt_q <= '0;
         end else if (state_q == MEASURE && !enter_to) begin
            cnt_q <= cnt_q + 32'd1;
         end
         if (capture) begin
            half_period_count <= cnt_q;
            prev_cap_q        <= cnt_q;
            has_prev_q        <= 1'b1;
            locked            <= has_prev_q && (lock_diff <= LOCK_TOL);
         end
         // Entering MEASURE discards history so the first capture never locks.
         if (clear_cnt) begin
            has_prev_q <= 1'b0;
            timeout    <= 1'b0;
         end
         if (enter_to) begin
            timeout <= 1'b1;
            locked  <= 1'b0;
         end
      end
   end

`ifdef MEAS_MATCH_EN
   logic [31:0] match_diff;
   assign match_diff = (cnt_q >= expected_count) ? (cnt_q - expected_count)
                                                 : (expected_count - cnt_q);

   always_ff @(posedge inclk or negedge Reset) begin
      if (!Reset) begin
         match <= 1'b0;
      end else if (capture) begin
         match <= (match_diff <= MATCH_TOL);
      end else if (enter_to) begin
         match <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_divided_clk_period_meter.sv
// tb/tb_divided_clk_period_meter.sv - directed bench for divided_clk_period_meter
module tb_divided_clk_period_meter;

   localparam logic [31:0] TO = 32'd100;

   logic        inclk = 1'b0;
   logic        Reset;
   logic        sig_in;
   logic [31:0] hpc1, hpc2;
   logic        mv1, mv2, lk1, lk2, to1, to2;
`ifdef MEAS_MATCH_EN
   logic [31:0] exp_count;
   logic        m1, m2, m3, mv3, lk3, to3;
   logic [31:0] hpc3;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] cap1_val[$];
   logic        cap1_lock[$];
   logic [31:0] cap2_val[$];
   logic        cap2_lock[$];

   always #5 inclk = ~inclk;

   divided_clk_period_meter #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO), .LOCK_TOL(32'd1)) u_dut1 (
      .inclk(inclk), .Reset(Reset), .sig_in(sig_in),
`ifdef MEAS_MATCH_EN
      .expected_count(exp_count), .match(m1),
`endif
      .half_period_count(hpc1), .meas_valid(mv1), .locked(lk1), .timeout(to1)
   );

   divided_clk_period_meter #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO), .LOCK_TOL(32'd2)) u_dut2 (
      .inclk(inclk), .Reset(Reset), .sig_in(sig_in),
`ifdef MEAS_MATCH_EN
      .expected_count(exp_count), .match(m2),
`endif
      .half_period_count(hpc2), .meas_valid(mv2), .locked(lk2), .timeout(to2)
   );

`ifdef MEAS_MATCH_EN
   divided_clk_period_meter #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(32'd30000)) u_dut3 (
      .inclk(inclk), .Reset(Reset), .sig_in(sig_in),
      .expected_count(exp_count), .match(m3),
      .half_period_count(hpc3), .meas_valid(mv3), .locked(lk3), .timeout(to3)
   );
`endif

   always @(negedge inclk) begin
      if (mv1) begin
         cap1_val.push_back(hpc1);
         cap1_lock.push_back(lk1);
      end
      if (mv2) begin
         cap2_val.push_back(hpc2);
         cap2_lock.push_back(lk2);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic toggle_wait(input int n);
      sig_in = ~sig_in;
      repeat (n) @(posedge inclk);
      #1;
   endtask

   task automatic clear_caps();
      cap1_val.delete();
      cap1_lock.delete();
      cap2_val.delete();
      cap2_lock.delete();
   endtask

   task automatic check_caps1(input string tag, input logic [31:0] vals[$], input logic locks[$]);
      check({tag, "_count"}, cap1_val.size(), vals.size());
      for (int i = 0; i < vals.size() && i < cap1_val.size(); i++) begin
         check($sformatf("%s_val%0d", tag, i), cap1_val[i], vals[i]);
         check($sformatf("%s_lock%0d", tag, i), {31'd0, cap1_lock[i]}, {31'd0, locks[i]});
      end
   endtask

   initial begin
      logic        found;
      int          nsnap;
      logic [31:0] v[$];
      logic        l[$];

      Reset  = 1'b0;
      sig_in = 1'b0;
`ifdef MEAS_MATCH_EN
      exp_count = 32'h61A6;
`endif
      #12;
      check("rst_hpc", hpc1, 32'd0);
      check("rst_valid", {31'd0, mv1}, 32'd0);
      check("rst_locked", {31'd0, lk1}, 32'd0);
      check("rst_timeout", {31'd0, to1}, 32'd0);
      check("rst_hpc2", hpc2, 32'd0);
      @(posedge inclk); #1;
      Reset = 1'b1;
      repeat (3) @(posedge inclk);
      #1;

      // N=3: first edge arms, five later edges capture 3
      clear_caps();
      repeat (6) toggle_wait(4);
      v = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd3};
      l = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      check_caps1("n3", v, l);
      check("n3_timeout", {31'd0, to1}, 32'd0);

      // Switch to N=25
      clear_caps();
      repeat (3) toggle_wait(26);
      v = '{32'd3, 32'd25, 32'd25};
      l = '{1'b1, 1'b0, 1'b1};
      check_caps1("n25", v, l);

      // Asymmetric 10/12 wave
      clear_caps();
      toggle_wait(10);
      toggle_wait(12);
      toggle_wait(10);
      toggle_wait(12);
      v = '{32'd25, 32'd9, 32'd11, 32'd9};
      l = '{1'b1, 1'b0, 1'b0, 1'b0};
      check_caps1("asym", v, l);
      check("asym2_count", cap2_val.size(), 32'd4);
      if (cap2_val.size() == 4) begin
         check("asym2_lock1", {31'd0, cap2_lock[1]}, 32'd0);
         check("asym2_lock2", {31'd0, cap2_lock[2]}, 32'd1);
         check("asym2_lock3", {31'd0, cap2_lock[3]}, 32'd1);
      end

      // Last edge, then hold: timeout after cnt reaches TO
      sig_in = ~sig_in;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(posedge inclk); #1;
         if (mv1) found = 1'b1;
      end
      check("to_capture_seen", {31'd0, found}, 32'd1);
      check("to_cap_val", hpc1, 32'd11);
      check("to_lock2_before", {31'd0, lk2}, 32'd1);
      repeat (TO) @(posedge inclk);
      #1;
      check("to_not_yet", {31'd0, to1}, 32'd0);
      @(posedge inclk); #1;
      check("to_set", {31'd0, to1}, 32'd1);
      check("to_locked_clr", {31'd0, lk1}, 32'd0);
      check("to_set2", {31'd0, to2}, 32'd1);
      check("to_locked2_clr", {31'd0, lk2}, 32'd0);
      check("to_hold_hpc", hpc1, 32'd11);
      check("to_hold_hpc2", hpc2, 32'd11);
      repeat (5) @(posedge inclk);
      #1;
      nsnap = cap1_val.size();
      toggle_wait(8);
      check("to_exit_noval", cap1_val.size(), nsnap);
      check("to_exit_clr", {31'd0, to1}, 32'd0);
      toggle_wait(8);
      check("to_after_count", cap1_val.size(), nsnap + 1);
      check("to_after_val", hpc1, 32'd7);
      check("to_after_lock", {31'd0, lk1}, 32'd0);

      // Async reset mid-interval
      repeat (4) toggle_wait(5);
      check("pre_rst_hpc", hpc1, 32'd4);
      check("pre_rst_lock", {31'd0, lk1}, 32'd1);
      sig_in = ~sig_in;
      repeat (2) @(posedge inclk);
      #3;
      Reset = 1'b0;
      #1;
      check("arst_hpc", hpc1, 32'd0);
      check("arst_lock", {31'd0, lk1}, 32'd0);
      check("arst_valid", {31'd0, mv1}, 32'd0);
      check("arst_timeout", {31'd0, to1}, 32'd0);
      sig_in = 1'b0;
      repeat (3) @(posedge inclk);
      #1;
      Reset = 1'b1;
      repeat (3) @(posedge inclk);
      #1;
      clear_caps();
      toggle_wait(7);
      toggle_wait(7);
      v = '{32'd6};
      l = '{1'b0};
      check_caps1("post_rst", v, l);

`ifdef MEAS_MATCH_EN
      toggle_wait(32'h61AA);
      toggle_wait(32'h61A8);
      check("match_hpc_far", hpc3, 32'h61A9);
      check("match_far", {31'd0, m3}, 32'd0);
      sig_in = ~sig_in;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(posedge inclk); #1;
         if (mv3) found = 1'b1;
      end
      check("match_near_seen", {31'd0, found}, 32'd1);
      check("match_hpc_near", hpc3, 32'h61A7);
      check("match_near", {31'd0, m3}, 32'd1);
      repeat (30010) @(posedge inclk);
      #1;
      check("match_to", {31'd0, to3}, 32'd1);
      check("match_to_clr", {31'd0, m3}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
